// File: rtl/sh7034_ibus_pkg.sv
// Shared types and constants for the SH7034 instruction-bus prefetcher.
package sh7034_ibus_pkg;

  typedef logic [27:0] ibus_addr_t;

  localparam logic [3:0] BA_LONG = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } pf_state_t;

  // Longword-align a bus address.
  function automatic ibus_addr_t lw_align(input ibus_addr_t a);
    return a & ~28'h3;
  endfunction

endpackage

// File: rtl/sh7034_pfq.sv
// Halfword opcode FIFO: accepts 0/1/2 halfwords and releases 0/1 per enabled edge.
module sh7034_pfq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     flush,
  input  logic [1:0]               push_n,
  input  logic [15:0]              push_d0,
  input  logic [15:0]              push_d1,
  input  logic                     pop,
  output logic [15:0]              head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW:0]   count_q, count_d;

  // Next pointers, occupancy and storage contents; flush discards everything.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (ce) begin
      if (flush) begin
        rd_d    = '0;
        wr_d    = '0;
        count_d = '0;
      end else begin
        if (push_n != 2'd0) mem_d[wr_q] = push_d0;
        if (push_n == 2'd2) mem_d[wr_q + PW'(1)] = push_d1;
        wr_d    = wr_q + PW'(push_n);
        rd_d    = rd_q + PW'(pop);
        count_d = count_q + (PW+1)'(push_n) - (PW+1)'(pop);
      end
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Opcode storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/sh7034_ibus_prefetch.sv
// IBUS longword fetcher feeding the decoder with big-endian halfword opcodes.
module sh7034_ibus_prefetch
  import sh7034_ibus_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [27:0] RESET_PC = 28'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  output logic [27:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  input  logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT,
  input  logic        IF_JUMP,
  input  logic [27:0] IF_JUMP_PC,
  output logic        IF_VALID,
  output logic [15:0] IF_DATA,
  output logic [27:0] IF_PC,
  input  logic        IF_ACK
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t  state_q, state_d;
  ibus_addr_t addr_q, addr_d;
  ibus_addr_t pend_q, pend_d;
  ibus_addr_t pc_q, pc_d;
  logic       skip_q, skip_d;

  logic [CW-1:0] q_count;
  logic [15:0]   q_head;
  logic [CW-1:0] cnt_next;
  logic [1:0]    push_n;
  logic          pop, flush, done, push_go, space_ok;
  ibus_addr_t    jmp_a;
  logic          unused_ok;

  // CE_F and IBUS_ACT carry no information this initiator needs.
  assign unused_ok = ^{CE_F, IBUS_ACT, IF_JUMP_PC[0]};

  assign jmp_a    = lw_align(IF_JUMP_PC);
  assign flush    = CE_R & IF_JUMP;
  assign pop      = CE_R & IF_ACK & IF_VALID & ~IF_JUMP;
  assign done     = CE_R & (state_q != IDLE) & ~IBUS_BUSY;
  assign push_go  = done & (state_q == REQ) & ~IF_JUMP;
  assign push_n   = !push_go ? 2'd0 : (skip_q ? 2'd1 : 2'd2);
  // Only one longword is ever outstanding, so post-edge occupancy decides issue.
  assign cnt_next = q_count + CW'(push_n) - CW'(pop);
  assign space_ok = (int'(cnt_next) <= DEPTH - 2);

  sh7034_pfq #(.DEPTH(DEPTH)) u_q (
    .clk     (CLK),
    .rst_n   (RST_N),
    .ce      (CE_R),
    .flush   (flush),
    .push_n  (push_n),
    .push_d0 (skip_q ? IBUS_DI[15:0] : IBUS_DI[31:16]),
    .push_d1 (IBUS_DI[15:0]),
    .pop     (pop),
    .head    (q_head),
    .count   (q_count)
  );

  // Fetch FSM plus address, skip and head-PC bookkeeping; a redirect overrides all.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    skip_d  = skip_q;
    if (CE_R) begin
      if (pop) pc_d = pc_q + 28'd2;
      case (state_q)
        IDLE: begin
          if (IF_JUMP) begin
            addr_d  = jmp_a;
            state_d = REQ;
          end else if (space_ok) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (IF_JUMP) begin
            if (IBUS_BUSY) begin
              pend_d  = jmp_a;
              state_d = DROP;
            end else begin
              addr_d  = jmp_a;
              state_d = REQ;
            end
          end else if (!IBUS_BUSY) begin
            addr_d  = addr_q + 28'd4;
            skip_d  = 1'b0;
            state_d = space_ok ? REQ : IDLE;
          end
        end
        DROP: begin
          if (IF_JUMP) pend_d = jmp_a;
          if (!IBUS_BUSY) begin
            addr_d  = IF_JUMP ? jmp_a : pend_q;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
      if (IF_JUMP) begin
        skip_d = IF_JUMP_PC[1];
        pc_d   = IF_JUMP_PC & ~28'h1;
      end
    end
  end

  // State and address registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= lw_align(RESET_PC);
      pend_q  <= lw_align(RESET_PC);
      pc_q    <= RESET_PC & ~28'h1;
      skip_q  <= RESET_PC[1];
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

  assign IBUS_A   = addr_q;
  assign IBUS_DO  = 32'h0;
  assign IBUS_BA  = BA_LONG;
  assign IBUS_WE  = 1'b0;
  assign IBUS_REQ = (state_q != IDLE);
  assign IF_VALID = (q_count != '0);
  assign IF_DATA  = IF_VALID ? q_head : 16'h0;
  assign IF_PC    = pc_q;

endmodule

// File: tb/tb_sh7034_ibus_prefetch.sv
// Directed plus randomized bench for the IBUS prefetcher against an opcode-stream model.
module tb_sh7034_ibus_prefetch;

  logic        clk = 1'b0;
  logic        rst_n, ce_r, ce_f, busy, act, jump, ack;
  logic [27:0] jpc, ibus_a, if_pc;
  logic [31:0] ibus_do, ibus_di;
  logic [3:0]  ibus_ba;
  logic        ibus_we, ibus_req, if_valid;
  logic [15:0] if_data;

  int          total = 0;
  int          bad   = 0;
  logic [27:0] exp_pc;

  always #5 clk = ~clk;

  // Memory image: the opcode stored at halfword address pc.
  function automatic logic [15:0] op(input logic [27:0] pc);
    return pc[15:0] ^ pc[27:12] ^ 16'h5A3C;
  endfunction

  // Zero-wait responder returning the longword at IBUS_A, big-endian.
  assign ibus_di = {op(ibus_a), op(ibus_a + 28'd2)};

  sh7034_ibus_prefetch #(.DEPTH(4), .RESET_PC(28'h0)) u_dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .CE_R       (ce_r),
    .CE_F       (ce_f),
    .IBUS_A     (ibus_a),
    .IBUS_DO    (ibus_do),
    .IBUS_DI    (ibus_di),
    .IBUS_BA    (ibus_ba),
    .IBUS_WE    (ibus_we),
    .IBUS_REQ   (ibus_req),
    .IBUS_BUSY  (busy),
    .IBUS_ACT   (act),
    .IF_JUMP    (jump),
    .IF_JUMP_PC (jpc),
    .IF_VALID   (if_valid),
    .IF_DATA    (if_data),
    .IF_PC      (if_pc),
    .IF_ACK     (ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One enabled edge: check the head against the model, advance the model, clock.
  task automatic cyc();
    if (ce_r && rst_n) begin
      chk("head_pc", {4'h0, if_pc}, {4'h0, exp_pc});
      if (if_valid) chk("head_data", {16'h0, if_data}, {16'h0, op(exp_pc)});
      if (jump) exp_pc = jpc & ~28'h1;
      else if (ack && if_valid) exp_pc = exp_pc + 28'd2;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ce_r = 1'b1; ce_f = 1'b0; busy = 1'b0; act = 1'b1;
    jump = 1'b0; ack = 1'b0; jpc = '0; exp_pc = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req", ibus_req, 0);
    chk("rst_addr", ibus_a, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_data", if_data, 0);
    chk("rst_pc", if_pc, 0);
    chk("const_ba", ibus_ba, 4'hF);
    chk("const_we", ibus_we, 0);
    chk("const_do", ibus_do, 0);
    rst_n = 1'b1;

    // Fill from reset with a busy stretch on the second longword.
    cyc();
    chk("fill_req0", ibus_req, 1);
    chk("fill_a0", ibus_a, 28'h0);
    chk("fill_valid0", if_valid, 0);
    cyc();
    chk("fill_a1", ibus_a, 28'h4);
    chk("fill_valid1", if_valid, 1);
    chk("fill_data1", if_data, op(28'h0));
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("busy_a", ibus_a, 28'h4);
      chk("busy_req", ibus_req, 1);
      chk("busy_cnt", u_dut.u_q.count_q, 2);
    end
    busy = 1'b0;
    cyc();
    chk("full_req", ibus_req, 0);
    chk("full_a", ibus_a, 28'h8);
    chk("full_cnt", u_dut.u_q.count_q, 4);
    chk("full_pc", if_pc, 0);
    cyc();
    chk("full_idle", ibus_req, 0);

    // Drain a few opcodes in order.
    ack = 1'b1;
    repeat (4) cyc();
    ack = 1'b0;

    // Redirect to an odd halfword: only the low half of 0x100 is kept.
    jump = 1'b1; jpc = 28'h102;
    cyc();
    jump = 1'b0;
    chk("j102_valid", if_valid, 0);
    chk("j102_a", ibus_a, 28'h100);
    chk("j102_req", ibus_req, 1);
    chk("j102_pc", if_pc, 28'h102);
    cyc();
    chk("j102_valid2", if_valid, 1);
    chk("j102_data", if_data, op(28'h102));
    chk("j102_cnt", u_dut.u_q.count_q, 1);
    chk("j102_next", ibus_a, 28'h104);

    // Redirect while the responder stalls a read of 0x8.
    jump = 1'b1; jpc = 28'h8;
    cyc();
    jump = 1'b0; busy = 1'b1;
    chk("j8_a", ibus_a, 28'h8);
    cyc();
    chk("j8_hold", ibus_a, 28'h8);
    jump = 1'b1; jpc = 28'h200;
    cyc();
    jump = 1'b0;
    chk("drop_req", ibus_req, 1);
    chk("drop_a", ibus_a, 28'h8);
    chk("drop_valid", if_valid, 0);
    chk("drop_pc", if_pc, 28'h200);
    cyc();
    chk("drop_a2", ibus_a, 28'h8);
    busy = 1'b0;
    cyc();
    chk("drop_done_a", ibus_a, 28'h200);
    chk("drop_done_valid", if_valid, 0);
    chk("drop_done_cnt", u_dut.u_q.count_q, 0);
    cyc();
    chk("j200_valid", if_valid, 1);
    chk("j200_data", if_data, op(28'h200));
    chk("j200_next", ibus_a, 28'h204);

    // Jump, pop and completion on the same edge.
    ack = 1'b1; jump = 1'b1; jpc = 28'h300;
    cyc();
    jump = 1'b0; ack = 1'b0;
    chk("sim_valid", if_valid, 0);
    chk("sim_cnt", u_dut.u_q.count_q, 0);
    chk("sim_a", ibus_a, 28'h300);
    chk("sim_req", ibus_req, 1);

    // Address wrap at the top of the 28-bit space with continuous pops.
    ack = 1'b1; jump = 1'b1; jpc = 28'hFFFFFFC;
    cyc();
    jump = 1'b0;
    chk("wrap_a0", ibus_a, 28'hFFFFFFC);
    cyc();
    chk("wrap_a1", ibus_a, 28'h0);
    chk("wrap_pc0", if_pc, 28'hFFFFFFC);
    cyc();
    cyc();
    chk("wrap_pc", if_pc, 28'h0);
    chk("wrap_valid", if_valid, 1);

    // Clock enable low freezes everything.
    begin
      logic [27:0] a_hold;
      logic [31:0] c_hold;
      a_hold = ibus_a; c_hold = 32'(u_dut.u_q.count_q);
      ce_r = 1'b0;
      repeat (3) cyc();
      chk("ce_a", ibus_a, a_hold);
      chk("ce_cnt", u_dut.u_q.count_q, c_hold);
      ce_r = 1'b1;
    end
    ack = 1'b0;

    // Randomized traffic checked against the opcode-stream model.
    for (int i = 0; i < 400; i++) begin
      busy = ($urandom_range(0, 9) < 3);
      ack  = ($urandom_range(0, 9) < 6);
      jump = ($urandom_range(0, 19) == 0);
      jpc  = 28'($urandom());
      cyc();
      chk("rnd_align", {30'h0, ibus_a[1:0]}, 0);
    end

    // The pipeline must deliver again once the bus is quiet.
    busy = 1'b0; ack = 1'b0; jump = 1'b0;
    begin
      int n = 0;
      while (!if_valid && n < 10) begin
        cyc();
        n++;
      end
    end
    chk("liveness", if_valid, 1);

    // Reset is honoured with the clock enable low.
    rst_n = 1'b0; ce_r = 1'b0;
    @(posedge clk); #1;
    chk("rst2_req", ibus_req, 0);
    chk("rst2_valid", if_valid, 0);
    chk("rst2_a", ibus_a, 0);
    chk("rst2_pc", if_pc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
